// File: rtl/tl_left_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tl_left_sequencer
// Description : Moore sequencer for a two-street traffic light with protected
//               left-turn phases. Steps through eight phases (A green, A
//               yellow, A left, A yellow, B green, B yellow, B left, B yellow).
//               A per-phase dwell timer enforces minimum green, maximum green
//               and fixed yellow durations.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   synchronous active-high reset
//   ta / tal   in   1   street A straight / left-turn traffic present
//   tb / tbl   in   1   street B straight / left-turn traffic present
//   la / lb    out  2   lamp codes: 00 green, 01 yellow, 10 left, 11 red
//   state      out  3   current phase register (S0..S7)
//   dwell      out  TW  cycles spent in current phase minus 1 (saturating)
//   phase_adv  out  1   high when the next edge moves to the next phase
// ============================================================================
module tl_left_sequencer #(
  parameter int YELLOW_CYCLES = 2,
  parameter int MIN_GREEN     = 4,
  parameter int MAX_GREEN     = 16,
  parameter int TW            = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ta,
  input  logic          tal,
  input  logic          tb,
  input  logic          tbl,
  output logic [1:0]    la,
  output logic [1:0]    lb,
  output logic [2:0]    state,
  output logic [TW-1:0] dwell,
  output logic          phase_adv
);

  // Phase encoding
  localparam logic [2:0] c_S0 = 3'd0;  // A green  / B red
  localparam logic [2:0] c_S1 = 3'd1;  // A yellow / B red
  localparam logic [2:0] c_S2 = 3'd2;  // A left   / B red
  localparam logic [2:0] c_S3 = 3'd3;  // A yellow / B red
  localparam logic [2:0] c_S4 = 3'd4;  // A red    / B green
  localparam logic [2:0] c_S5 = 3'd5;  // A red    / B yellow
  localparam logic [2:0] c_S6 = 3'd6;  // A red    / B left
  localparam logic [2:0] c_S7 = 3'd7;  // A red    / B yellow

  // Lamp codes
  localparam logic [1:0] c_LAMP_GREEN  = 2'b00;
  localparam logic [1:0] c_LAMP_YELLOW = 2'b01;
  localparam logic [1:0] c_LAMP_LEFT   = 2'b10;
  localparam logic [1:0] c_LAMP_RED    = 2'b11;

  // Timer thresholds expressed as "last dwell value" of the interval
  localparam logic [TW-1:0] c_MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] c_MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] c_YEL_LAST = TW'(YELLOW_CYCLES - 1);
  localparam logic [TW-1:0] c_DWELL_SAT = {TW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] dwell_q, dwell_d;
  logic          w_sensor;
  logic          w_advance;

  // Even phases are green/left phases; state[2:1] picks which sensor
  // governs the phase (ta, tal, tb, tbl in phase order).
  always_comb begin
    w_sensor = 1'b0;
    case (state_q[2:1])
      2'd0:    w_sensor = ta;
      2'd1:    w_sensor = tal;
      2'd2:    w_sensor = tb;
      default: w_sensor = tbl;
    endcase
  end

  always_comb begin
    w_advance = 1'b0;
    if (state_q[0]) begin
      // Yellow phases have a fixed length
      w_advance = (dwell_q == c_YEL_LAST);
    end else begin
      // Minimum green is honoured regardless of the sensor; after that the
      // phase ends once demand disappears or the maximum is reached.
      w_advance = (dwell_q >= c_MIN_LAST) &&
                  (!w_sensor || (dwell_q == c_MAX_LAST));
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    if (w_advance) begin
      state_d = state_q + 3'd1;  // 3-bit wrap takes S7 back to S0
      dwell_d = '0;
    end else if (dwell_q != c_DWELL_SAT) begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_S0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
    end
  end

  // Lamp decode: exactly one street is non-red in every phase
  always_comb begin
    la = c_LAMP_RED;
    lb = c_LAMP_RED;
    case (state_q)
      c_S0: begin la = c_LAMP_GREEN;  lb = c_LAMP_RED;    end
      c_S1: begin la = c_LAMP_YELLOW; lb = c_LAMP_RED;    end
      c_S2: begin la = c_LAMP_LEFT;   lb = c_LAMP_RED;    end
      c_S3: begin la = c_LAMP_YELLOW; lb = c_LAMP_RED;    end
      c_S4: begin la = c_LAMP_RED;    lb = c_LAMP_GREEN;  end
      c_S5: begin la = c_LAMP_RED;    lb = c_LAMP_YELLOW; end
      c_S6: begin la = c_LAMP_RED;    lb = c_LAMP_LEFT;   end
      c_S7: begin la = c_LAMP_RED;    lb = c_LAMP_YELLOW; end
      default: begin la = c_LAMP_RED; lb = c_LAMP_RED;    end
    endcase
  end

  assign state     = state_q;
  assign dwell     = dwell_q;
  assign phase_adv = w_advance;

endmodule
`default_nettype wire

// File: tb/tb_tl_left_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_left_sequencer
// Description : Self-checking bench for tl_left_sequencer: reset behaviour,
//               table of per-phase durations, hand-written corner sequences
//               and randomized sensors against a behavioural phase model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_left_sequencer;

  localparam int YELLOW_CYCLES = 2;
  localparam int MIN_GREEN     = 4;
  localparam int MAX_GREEN     = 16;
  localparam int TW            = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ta = 1'b0, tal = 1'b0, tb = 1'b0, tbl = 1'b0;
  logic [1:0]    la, lb;
  logic [2:0]    state;
  logic [TW-1:0] dwell;
  logic          phase_adv;

  int errors = 0;
  int checks = 0;

  tl_left_sequencer #(
    .YELLOW_CYCLES(YELLOW_CYCLES),
    .MIN_GREEN    (MIN_GREEN),
    .MAX_GREEN    (MAX_GREEN),
    .TW           (TW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ta       (ta),
    .tal      (tal),
    .tb       (tb),
    .tbl      (tbl),
    .la       (la),
    .lb       (lb),
    .state    (state),
    .dwell    (dwell),
    .phase_adv(phase_adv)
  );

  always #5 clk = ~clk;

  // Lamp code expected for each phase, street A and street B
  int la_tab[8] = '{0, 1, 2, 1, 3, 3, 3, 3};
  int lb_tab[8] = '{3, 3, 3, 3, 0, 1, 2, 1};

  typedef struct {
    logic ta, tal, tb, tbl;
    int   exp_state;
    int   exp_cycles;
    int   exp_la;
    int   exp_lb;
  } phase_vec_t;

  phase_vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive inputs and let combinational outputs settle
  task automatic apply(input logic a, input logic al, input logic b,
                       input logic bl, input logic r);
    ta = a; tal = al; tb = b; tbl = bl; reset = r;
    #1;
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 1);
    tick();
    tick();
    apply(0, 0, 0, 0, 0);
  endtask

  // Wait (bounded) until the state register shows the target phase
  task automatic wait_state(input int target, input string name);
    int n;
    n = 0;
    while (int'(state) != target && n < 100) begin
      tick();
      n++;
    end
    chk(name, int'(state), target);
  endtask

  // Behavioural model state
  int m_s, m_d;
  int prev_state;

  initial begin
    // ---------------- Test 1: reset then max green with ta held ----------
    apply(1, 0, 0, 0, 1);
    tick();
    apply(1, 0, 0, 0, 1);
    tick();
    chk("rst_state", int'(state), 0);
    chk("rst_dwell", int'(dwell), 0);
    chk("rst_la", int'(la), 0);
    chk("rst_lb", int'(lb), 3);
    chk("rst_phase_adv", int'(phase_adv), 0);
    apply(1, 0, 0, 0, 0);
    for (int i = 0; i < MAX_GREEN; i++) begin
      chk("t1_dwell", int'(dwell), i);
      chk("t1_state", int'(state), 0);
      chk("t1_phase_adv", int'(phase_adv), (i == MAX_GREEN - 1) ? 1 : 0);
      tick();
    end
    chk("t1_state_after_max", int'(state), 1);
    chk("t1_dwell_cleared", int'(dwell), 0);

    // ---------------- Table: per-phase durations -------------------------
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{0, 0, 0, 0, k, (k % 2 == 1) ? YELLOW_CYCLES : MIN_GREEN,
                  la_tab[k], lb_tab[k]};
      vecs[k + 8] = '{1, 1, 1, 1, k, (k % 2 == 1) ? YELLOW_CYCLES : MAX_GREEN,
                      la_tab[k], lb_tab[k]};
    end
    do_reset();
    for (int r = 0; r < 16; r++) begin
      int n;
      apply(vecs[r].ta, vecs[r].tal, vecs[r].tb, vecs[r].tbl, 0);
      chk("tab_entry_state", int'(state), vecs[r].exp_state);
      chk("tab_entry_dwell", int'(dwell), 0);
      chk("tab_la", int'(la), vecs[r].exp_la);
      chk("tab_lb", int'(lb), vecs[r].exp_lb);
      n = 0;
      while (int'(state) == vecs[r].exp_state && n < 40) begin
        tick();
        n++;
      end
      chk("tab_duration", n, vecs[r].exp_cycles);
    end
    chk("tab_wrap_to_s0", int'(state), 0);

    // ---------------- Test 3: sensor drop before minimum green -----------
    do_reset();
    apply(1, 0, 0, 0, 0);
    tick();
    apply(0, 0, 0, 0, 0);
    chk("t3_dwell1", int'(dwell), 1);
    chk("t3_pa_d1", int'(phase_adv), 0);
    tick();
    chk("t3_pa_d2", int'(phase_adv), 0);
    chk("t3_state_d2", int'(state), 0);
    tick();
    chk("t3_dwell3", int'(dwell), 3);
    chk("t3_pa_d3", int'(phase_adv), 1);
    tick();
    chk("t3_state_next", int'(state), 1);

    // ---------------- Test 4: forced advance out of A left ----------------
    apply(0, 1, 0, 0, 0);
    wait_state(2, "t4_reach_s2");
    for (int i = 0; i < MAX_GREEN; i++) begin
      chk("t4_la_left", int'(la), 2);
      tick();
    end
    chk("t4_state_s3", int'(state), 3);
    chk("t4_la_yellow", int'(la), 1);

    // ---------------- Test 5: reset in the middle of S5 -------------------
    apply(0, 0, 0, 0, 0);
    wait_state(5, "t5_reach_s5");
    tick();
    chk("t5_dwell1", int'(dwell), 1);
    apply(0, 0, 0, 0, 1);
    tick();
    chk("t5_state", int'(state), 0);
    chk("t5_dwell", int'(dwell), 0);
    chk("t5_la", int'(la), 0);
    chk("t5_lb", int'(lb), 3);

    // ---------------- Test 6: random sensors vs. phase model -------------
    m_s = 0;
    m_d = 0;
    prev_state = 0;
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] sens;
      logic       r;
      logic       m_adv;
      int         s_val;
      sens = 4'($urandom);
      r    = ($urandom_range(0, 99) == 0);
      apply(sens[0], sens[1], sens[2], sens[3], r);

      // Reference: yellow lasts a fixed time; green/left honours the
      // minimum, then ends on no demand or at the maximum.
      if (m_s % 2 == 1) begin
        m_adv = (m_d == YELLOW_CYCLES - 1);
      end else begin
        s_val = int'(sens[m_s / 2]);
        m_adv = (m_d >= MIN_GREEN - 1) && (s_val == 0 || m_d == MAX_GREEN - 1);
      end

      chk("rnd_state", int'(state), m_s);
      chk("rnd_dwell", int'(dwell), m_d);
      chk("rnd_la", int'(la), la_tab[m_s]);
      chk("rnd_lb", int'(lb), lb_tab[m_s]);
      chk("rnd_phase_adv", int'(phase_adv), int'(m_adv));
      chk("rnd_safety", int'(la != 2'b11 && lb != 2'b11), 0);

      if (r) begin
        m_s = 0;
        m_d = 0;
      end else if (m_adv) begin
        m_s = (m_s + 1) % 8;
        m_d = 0;
      end else begin
        m_d = (m_d + 1 > (1 << TW) - 1) ? (1 << TW) - 1 : m_d + 1;
      end
      prev_state = int'(state);
      tick();
      if (!r) begin
        chk("rnd_step", int'(state == 3'(prev_state) || state == 3'(prev_state + 1)), 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
